// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//
// Branch-resolution and run-control block sitting directly in front of the
// instruction fetch stage. It keeps the compare flag and resolves conditional
// branches through a writable 16-entry target lookup table. It drives the
// Branch/Target pair that fetch samples on its next rising edge, sequences the
// program run state (IDLE / RUN / DONE) and counts taken branches for debug.
//
// Ports
//   Clk          in   single clock, all state updates on the rising edge
//   Reset        in   asynchronous, active-low; clears all state at once
//   Start        in   begin (or restart) program execution
//   LutWe        in   target LUT write enable (ignored while running)
//   LutAddr      in   LUT write address
//   LutData      in   LUT write data (absolute target)
//   InstValid    in   decoded instruction fields are valid this cycle
//   IsBranch     in   current instruction is a branch
//   BrCond       in   00 always, 01 if flag=1, 10 if flag=0, 11 never
//   BrIdx        in   LUT index of branch target
//   IsCmp        in   current instruction is a compare
//   CmpEq        in   compare result (1 = equal)
//   IsHalt       in   current instruction is halt
//   Branch       out  branch taken (combinational)
//   Target       out  branch target, zero when not taken (combinational)
//   Running      out  high in RUN state (registered)
//   Done         out  high in DONE state (registered)
//   Flag         out  current compare flag (registered)
//   BranchCount  out  taken branches since last Start, saturating (registered)
//   DbgState     out  raw FSM state for observation: 0 IDLE, 1 RUN, 2 DONE
//
// Handshake: there is no valid/ready pair. InstValid qualifies the decoded
// fields for exactly one cycle and the block never stalls the decoder; the
// fetch stage consumes Branch/Target unconditionally at the next edge.
// -----------------------------------------------------------------------------
module branch_ctrl #(
   parameter int PC_W  = 10,
   parameter int IDX_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             LutWe,
   input  logic [IDX_W-1:0] LutAddr,
   input  logic [PC_W-1:0]  LutData,
   input  logic             InstValid,
   input  logic             IsBranch,
   input  logic [1:0]       BrCond,
   input  logic [IDX_W-1:0] BrIdx,
   input  logic             IsCmp,
   input  logic             CmpEq,
   input  logic             IsHalt,
   output logic             Branch,
   output logic [PC_W-1:0]  Target,
   output logic             Running,
   output logic             Done,
   output logic             Flag,
   output logic [CNT_W-1:0] BranchCount,
   output logic [1:0]       DbgState
);

   localparam int               LUT_D   = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic             flag_q,  flag_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [PC_W-1:0]  lut_q [LUT_D];

   logic             restart;   // entering RUN this edge
   logic             cond_ok;
   logic             taken;
   logic             lut_we;

   // ---------------------------------------------------------------------------
   // Branch resolution (combinational). The condition looks at the registered
   // flag only, so a compare in the same cycle as a branch does not affect it.
   // ---------------------------------------------------------------------------
   always_comb begin
      cond_ok = 1'b0;
      unique case (BrCond)
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = flag_q;
         2'b10:   cond_ok = ~flag_q;
         default: cond_ok = 1'b0;
      endcase
   end

   // Halt wins over branch: a halting instruction never redirects fetch.
   assign taken  = (state_q == ST_RUN) & InstValid & IsBranch & ~IsHalt & cond_ok;
   assign Branch = taken;
   assign Target = taken ? lut_q[BrIdx] : '0;

   // ---------------------------------------------------------------------------
   // Run-state FSM, next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d = ST_RUN;
               restart = 1'b1;
            end
         end
         ST_RUN: begin
            // Start is deliberately ignored while running.
            if (InstValid && IsHalt) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (Start) begin
               state_d = ST_RUN;
               restart = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Flag and taken-branch counter next-state. A restart can only happen
   // outside RUN, and compares/taken branches only inside RUN, so the two
   // never compete on the same edge.
   // ---------------------------------------------------------------------------
   always_comb begin
      flag_d = flag_q;
      if (restart) begin
         flag_d = 1'b0;
      end else if ((state_q == ST_RUN) && InstValid && IsCmp) begin
         flag_d = CmpEq;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (taken && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Table updates are only accepted while no program is running, so a target
   // can never change underneath an in-flight branch.
   assign lut_we = LutWe & (state_q != ST_RUN);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < LUT_D; i++) begin
            lut_q[i] <= '0;
         end
      end else if (lut_we) begin
         lut_q[LutAddr] <= LutData;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs
   // ---------------------------------------------------------------------------
   assign Running     = (state_q == ST_RUN);
   assign Done        = (state_q == ST_DONE);
   assign Flag        = flag_q;
   assign BranchCount = cnt_q;
   assign DbgState    = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
//
// Directed bench for branch_ctrl. A behavioural model tracks run mode, flag,
// counter and target table from the operational rules; a single compare
// process checks every DUT output against it on each falling edge and also
// drains a queue of hand-computed literal expectations posted by the driver.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic             Start = 1'b0;
  logic             LutWe = 1'b0;
  logic [IDX_W-1:0] LutAddr = '0;
  logic [PC_W-1:0]  LutData = '0;
  logic             InstValid = 1'b0;
  logic             IsBranch = 1'b0;
  logic [1:0]       BrCond = 2'b00;
  logic [IDX_W-1:0] BrIdx = '0;
  logic             IsCmp = 1'b0;
  logic             CmpEq = 1'b0;
  logic             IsHalt = 1'b0;
  logic             Branch;
  logic [PC_W-1:0]  Target;
  logic             Running;
  logic             Done;
  logic             Flag;
  logic [CNT_W-1:0] BranchCount;
  logic [1:0]       DbgState;

  branch_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .LutWe(LutWe),
    .LutAddr(LutAddr), .LutData(LutData), .InstValid(InstValid),
    .IsBranch(IsBranch), .BrCond(BrCond), .BrIdx(BrIdx), .IsCmp(IsCmp),
    .CmpEq(CmpEq), .IsHalt(IsHalt), .Branch(Branch), .Target(Target),
    .Running(Running), .Done(Done), .Flag(Flag), .BranchCount(BranchCount),
    .DbgState(DbgState)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: mode 0 = idle, 1 = running, 2 = done
  // ---------------------------------------------------------------------------
  int m_mode = 0;
  int m_flag = 0;
  int m_cnt  = 0;
  int m_lut [16];

  function automatic bit m_cond();
    case (BrCond)
      2'd0: return 1'b1;
      2'd1: return m_flag == 1;
      2'd2: return m_flag == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_taken();
    return (m_mode == 1) && InstValid && IsBranch && !IsHalt && m_cond();
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = 0;
      m_flag = 0;
      m_cnt  = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
    end else begin
      bit tk;
      int old_mode;
      tk = m_taken();
      old_mode = m_mode;
      if (LutWe && old_mode != 1) m_lut[LutAddr] = int'(LutData);
      if (old_mode != 1) begin
        if (Start) begin
          m_mode = 1;
          m_flag = 0;
          m_cnt  = 0;
        end
      end else begin
        if (InstValid && IsCmp) m_flag = int'(CmpEq);
        if (tk && m_cnt < 255) m_cnt = m_cnt + 1;
        if (InstValid && IsHalt) m_mode = 2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: literal expectations posted by the driver for this cycle
  // sel: 0 Branch, 1 Target, 2 Running, 3 Done, 4 Flag, 5 BranchCount
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    logic [31:0] act;
    logic [31:0] e;
    int s;
    string nm;
    bit tk;
    tk = m_taken();
    chk("model_branch", 32'(Branch), 32'(tk));
    chk("model_target", 32'(Target), tk ? 32'(m_lut[BrIdx]) : 32'd0);
    chk("model_running", 32'(Running), 32'(m_mode == 1));
    chk("model_done", 32'(Done), 32'(m_mode == 2));
    chk("model_flag", 32'(Flag), 32'(m_flag));
    chk("model_count", 32'(BranchCount), 32'(m_cnt));
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      case (s)
        0: act = 32'(Branch);
        1: act = 32'(Target);
        2: act = 32'(Running);
        3: act = 32'(Done);
        4: act = 32'(Flag);
        default: act = 32'(BranchCount);
      endcase
      chk(nm, act, e);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic lit(input string nm, input int sel, input logic [31:0] v);
    name_q.push_back(nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic cyc(input logic v, input logic br, input logic [1:0] c,
                     input logic [3:0] idx, input logic cmp, input logic eq,
                     input logic halt, input logic st);
    @(posedge Clk);
    #1;
    InstValid = v;   IsBranch = br; BrCond = c; BrIdx = idx;
    IsCmp = cmp;     CmpEq = eq;    IsHalt = halt;
    Start = st;      LutWe = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 2'd0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic lut_wr(input logic [3:0] a, input logic [9:0] d);
    idle();
    LutWe = 1'b1; LutAddr = a; LutData = d;
  endtask

  task automatic br(input logic [1:0] c, input logic [3:0] idx);
    cyc(1, 1, c, idx, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held: branch-like inputs must not produce anything
    cyc(1, 1, 2'd0, 4'd3, 0, 0, 0, 1);
    lit("rst_branch", 0, 0); lit("rst_target", 1, 0); lit("rst_running", 2, 0);
    lit("rst_done", 3, 0);   lit("rst_flag", 4, 0);   lit("rst_count", 5, 0);
    idle();
    @(posedge Clk); #4; Reset = 1'b1;   // release mid-cycle

    // LUT load in IDLE
    lut_wr(4'd3, 10'h008);
    lut_wr(4'd15, 10'h3FF);
    lut_wr(4'd5, 10'h155);

    // Start -> Running one edge later
    cyc(0, 0, 2'd0, 4'd0, 0, 0, 0, 1);
    lit("start_not_yet", 2, 0);
    idle();
    lit("start_running", 2, 1); lit("start_count", 5, 0);

    // Unconditional branch
    br(2'd0, 4'd3);
    lit("uncond_branch", 0, 1); lit("uncond_target", 1, 32'h008);
    idle();
    lit("uncond_count", 5, 1);

    // Conditional on flag
    cyc(1, 0, 2'd0, 4'd0, 1, 1, 0, 0);
    br(2'd2, 4'd15);
    lit("flag_set", 4, 1); lit("ifz_not_taken", 0, 0); lit("ifz_target0", 1, 0);
    br(2'd1, 4'd15);
    lit("ifs_taken", 0, 1); lit("ifs_target", 1, 32'h3FF);
    // Same-cycle compare (clearing flag) plus branch on old flag=1
    cyc(1, 1, 2'd1, 4'd3, 1, 0, 0, 0);
    lit("samecyc_branch", 0, 1); lit("samecyc_target", 1, 32'h008);
    br(2'd1, 4'd3);
    lit("flag_cleared", 4, 0); lit("ifs_after_clear", 0, 0);
    br(2'd2, 4'd5);
    lit("ifz_taken", 0, 1); lit("ifz_target", 1, 32'h155);
    br(2'd3, 4'd3);
    lit("never_branch", 0, 0);
    lit("count_mid", 5, 4);

    // LUT write during RUN is dropped
    idle();
    LutWe = 1'b1; LutAddr = 4'd3; LutData = 10'h111;
    br(2'd0, 4'd3);
    lit("lut_run_drop", 1, 32'h008);

    // Halt with branch: no branch, DONE next edge
    cyc(1, 1, 2'd0, 4'd3, 0, 0, 1, 0);
    lit("halt_no_branch", 0, 0);
    br(2'd0, 4'd3);
    lit("halt_done", 3, 1); lit("halt_running", 2, 0); lit("done_no_branch", 0, 0);
    lut_wr(4'd5, 10'h0AA);   // allowed outside RUN
    cyc(0, 0, 2'd0, 4'd0, 0, 0, 0, 1);
    lit("done_held", 3, 1);
    br(2'd0, 4'd15);
    lit("restart_running", 2, 1); lit("restart_flag", 4, 0);
    lit("restart_count", 5, 0);   lit("lut_retained", 1, 32'h3FF);
    br(2'd0, 4'd5);
    lit("lut_done_write", 1, 32'h0AA);

    // Saturation
    for (int i = 0; i < 300; i++) br(2'd0, 4'd15);
    br(2'd0, 4'd15);
    lit("sat_count", 5, 255); lit("sat_branch", 0, 1);
    br(2'd0, 4'd15);
    lit("sat_hold", 5, 255);

    // Asynchronous reset mid-cycle with a branch on the inputs
    @(posedge Clk); #2; Reset = 1'b0;
    lit("arst_branch", 0, 0); lit("arst_target", 1, 0);
    lit("arst_running", 2, 0); lit("arst_count", 5, 0);
    @(posedge Clk); #3; Reset = 1'b1;
    cyc(0, 0, 2'd0, 4'd0, 0, 0, 0, 1);
    br(2'd0, 4'd15);
    lit("arst_lut_cleared_br", 0, 1); lit("arst_lut_cleared_tgt", 1, 0);
    idle();

    @(posedge Clk);
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-resolution and run-control block sitting directly upstream of the instruction fetch stage. It takes decoded control fields for the current instruction and keeps a compare flag. It resolves conditional branches through a writable target lookup table and drives the `Branch`/`Target` pair that the fetch stage samples on its next clock edge. It also sequences program run state (idle, running, halted) and counts taken branches for debug.

## Interface
Parameters:
- `PC_W`, 10, width of program counter / branch target
- `IDX_W`, 4, LUT index width (LUT depth = 2**IDX_W = 16)
- `CNT_W`, 8, taken-branch counter width

Ports:
- `Clk`  in  1  single clock, all state updates on rising edge
- `Reset`  in  1  asynchronous, active-low; clears all state immediately
- `Start`  in  1  begin program execution (sampled on rising edge)
- `LutWe`  in  1  target LUT write enable
- `LutAddr`  in  IDX_W  LUT write address
- `LutData`  in  PC_W  LUT write data (absolute target)
- `InstValid`  in  1  decoded instruction fields below are valid this cycle
- `IsBranch`  in  1  current instruction is a branch
- `BrCond`  in  2  00 always, 01 if flag=1, 10 if flag=0, 11 never
- `BrIdx`  in  IDX_W  LUT index of branch target
- `IsCmp`  in  1  current instruction is a compare
- `CmpEq`  in  1  compare result (1 = equal)
- `IsHalt`  in  1  current instruction is halt
- `Branch`  out  1  branch taken, to fetch stage
- `Target`  out  PC_W  branch target, to fetch stage
- `Running`  out  1  high in RUN state
- `Done`  out  1  high in DONE state
- `Flag`  out  1  current compare flag
- `BranchCount`  out  CNT_W  taken branches since last Start

## Operation
- FSM states: IDLE, RUN, DONE. Reset (Reset=0) forces IDLE asynchronously.
- IDLE: Start=1 -> RUN. All other inputs are ignored except LUT writes.
- RUN: InstValid & IsHalt -> DONE. Start is ignored.
- DONE: Start=1 -> RUN (restart). Done stays high until then.
- Every IDLE->RUN or DONE->RUN transition clears Flag and BranchCount on that same edge.
- LUT: 16 x PC_W registers. A write with LutWe=1 takes effect at the rising edge only when the state is not RUN; writes during RUN are dropped. The LUT is not cleared by Start.
- Flag: in RUN, InstValid & IsCmp updates Flag <= CmpEq on the edge.
- Taken = (state==RUN) & InstValid & IsBranch & !IsHalt & cond. cond is evaluated against the current registered Flag.
- Branch = Taken, combinational. Target = LUT[BrIdx] when Taken, else all zeros.
- Same-cycle IsCmp & IsBranch: the branch uses the old Flag, and Flag updates at the edge.
- IsHalt has priority over IsBranch: no branch is taken and the state goes to DONE.
- BrCond=11 never branches. It is not an error.
- BranchCount increments on each edge where Taken=1 and saturates at 2**CNT_W-1 (255); no wrap.
- Reset values: state IDLE, Flag 0, BranchCount 0, all LUT entries 0. Branch 0, Target 0, Running 0, Done 0.

## Timing
- `Branch`/`Target` are valid in the same cycle as the instruction fields. The fetch stage loads `Target` at the next rising edge, which gives one-cycle redirect latency.
- Start -> Running=1 one edge later.
- Halt seen in cycle N -> Done=1 after edge N; Running=0 at the same time.
- LUT write at edge N is readable via Target from cycle N+1.
- Reset deasserting mid-cycle takes effect at once, with no synchronizer inside the block. Asserting Reset during RUN drops Branch to 0 immediately.
- Outputs `Running`, `Done`, `Flag`, `BranchCount` are registered. `Branch` and `Target` are combinational from the registered state plus inputs.

## Test plan
- Reset then LUT load: Reset=0 -> all outputs 0. Then in IDLE write LUT[3]=0x008 and LUT[15]=0x3FF. Start -> Running=1, BranchCount=0.
- Unconditional branch: in RUN, InstValid, IsBranch, BrCond=00, BrIdx=3 -> Branch=1, Target=0x008 that cycle. BranchCount=1 after the edge.
- Conditional on flag: IsCmp, CmpEq=1, then BrCond=10, BrIdx=15 -> Branch=0. Next BrCond=01 -> Branch=1, Target=0x3FF. Same-cycle cmp+branch uses the old Flag.
- Halt priority and restart: IsHalt & IsBranch together -> Branch=0, Done=1 next edge. Start -> RUN with Flag=0, BranchCount=0, and the LUT retained.
- LUT write ignored in RUN: LutWe with LUT[3]=0x111 during RUN -> a later branch to idx 3 still gives 0x008.
- Saturation and async reset: 300 taken branches -> BranchCount=255. Assert Reset mid-cycle -> Branch, Running and BranchCount go to 0 before the next edge.
